// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// default bit rate used by both the transmit serializer and the future receiver.
package uart_pkg;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: bit_end_o marks the last cycle of each bit
// period; clear_i holds the count at zero so the next period starts cleanly.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_end_o = (cnt_q == CNT_LAST);

    // Wrapping at the period end doubles as the per-state counter restart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i || bit_end_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a show-ahead FIFO and sends them
// LSB first as start/8 data/optional parity/1-2 stop frames, back-to-back.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_read_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       tx_done_o
);

    localparam logic HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic STOP_LAST  = (STOP_BITS == 2);

    tx_state_e  state_q;
    logic [7:0] shift_q;
    logic       parity_q;
    logic [2:0] bit_idx_q;
    logic       stop_idx_q;
    logic       tx_q;
    logic       busy_q;

    logic       bit_end;
    logic       frame_end;
    logic       load;
    logic       parity_d;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_q == ST_IDLE),
        .bit_end_o(bit_end)
    );

    assign frame_end = (state_q == ST_STOP) && bit_end && (stop_idx_q == STOP_LAST);

    // The pop is combinational so a waiting byte can follow the last stop cycle
    // with no gap; it is held off during reset even though state reads IDLE.
    assign load     = rst_ni && !fifo_empty_i && ((state_q == ST_IDLE) || frame_end);
    assign parity_d = parity_bit(fifo_data_i, PARITY);

    assign fifo_read_o = load;
    assign tx_done_o   = frame_end;
    assign tx_o        = tx_q;
    assign busy_o      = busy_q;

    // tx_q/busy_q are loaded with the value for the state being entered, so
    // the line changes on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_q  <= ST_START;
                        shift_q  <= fifo_data_i;
                        parity_q <= parity_d;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            stop_idx_q <= 1'b0;
                            if (HAS_PARITY) begin
                                state_q <= ST_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        state_q    <= ST_STOP;
                        stop_idx_q <= 1'b0;
                        tx_q       <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_idx_q != STOP_LAST) begin
                            stop_idx_q <= stop_idx_q + 1'b1;
                        end else if (load) begin
                            state_q    <= ST_START;
                            shift_q    <= fifo_data_i;
                            parity_q   <= parity_d;
                            stop_idx_q <= 1'b0;
                            tx_q       <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            state_q    <= ST_IDLE;
                            stop_idx_q <= 1'b0;
                            tx_q       <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four serializers (no parity, even, odd, two stop bits)
// share one byte stream; every cycle is compared against a frame-timeline model.
module tb_uart_tx_serializer;

    localparam int C    = 4;
    localparam int NDUT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NDUT-1:0]  fe;
    logic [7:0]       fd [NDUT];
    logic [NDUT-1:0]  rd_w;
    logic [NDUT-1:0]  tx_w;
    logic [NDUT-1:0]  busy_w;
    logic [NDUT-1:0]  done_w;

    logic [7:0]       bytes_a [8];
    int               rp [NDUT];
    int               n_tests = 0;
    int               n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        uart_tx_serializer #(
            .CLKS_PER_BIT(C),
            .PARITY      ((gi == 1) ? 1 : (gi == 2) ? 2 : 0),
            .STOP_BITS   ((gi == 3) ? 2 : 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .fifo_empty_i(fe[gi]),
            .fifo_data_i (fd[gi]),
            .fifo_read_o (rd_w[gi]),
            .tx_o        (tx_w[gi]),
            .busy_o      (busy_w[gi]),
            .tx_done_o   (done_w[gi])
        );
    end

    function automatic int par_of(input int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int stop_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    // Bit b of the frame carrying byte v: start, 8 data LSB first, parity, stops.
    function automatic logic frame_bit(input int i, input logic [7:0] v, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return v[b-1];
        if (b == 9 && par_of(i) == 1) return ^v;
        if (b == 9 && par_of(i) == 2) return ~(^v);
        return 1'b1;
    endfunction

    // Expected {tx, busy, fifo_read, tx_done} in cycle j after n bytes became
    // available in cycle 0: frames run back-to-back starting at cycle 1.
    function automatic logic [3:0] exp_out(input int i, input int j, input int n);
        int  len;
        int  f;
        logic tx_e, busy_e, rd_e, done_e;
        len    = 1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i);
        f      = len * C;
        busy_e = (j >= 1) && (j <= n * f);
        rd_e   = (j == 0) || ((j % f == 0) && (j / f >= 1) && (j / f < n));
        done_e = (j > 0) && (j % f == 0) && (j / f >= 1) && (j / f <= n);
        tx_e   = 1'b1;
        if (busy_e) tx_e = frame_bit(i, bytes_a[(j - 1) / f], ((j - 1) % f) / C);
        return {tx_e, busy_e, rd_e, done_e};
    endfunction

    task automatic check(input string tag, input int i, input int j, input logic obs, input logic exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s dut%0d cyc%0d: observed %b expected %b", tag, i, j, obs, exp_v);
        end
    endtask

    task automatic check_all(input int j, input logic [3:0] e_fixed);
        for (int i = 0; i < NDUT; i++) begin
            check("tx",        i, j, tx_w[i],   e_fixed[3]);
            check("busy",      i, j, busy_w[i], e_fixed[2]);
            check("fifo_read", i, j, rd_w[i],   e_fixed[1]);
            check("tx_done",   i, j, done_w[i], e_fixed[0]);
        end
    endtask

    // One model cycle: compare at the falling edge, then emulate the FIFO pop.
    task automatic cycle(input int j, input int n);
        logic [NDUT-1:0] rd_s;
        logic [3:0]      e;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            e = exp_out(i, j, n);
            check("tx",        i, j, tx_w[i],   e[3]);
            check("busy",      i, j, busy_w[i], e[2]);
            check("fifo_read", i, j, rd_w[i],   e[1]);
            check("tx_done",   i, j, done_w[i], e[0]);
            rd_s[i] = rd_w[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            if (rd_s[i]) rp[i]++;
            fe[i] = (rp[i] >= n);
            fd[i] = (rp[i] < n) ? bytes_a[rp[i]] : 8'($urandom);
        end
    endtask

    task automatic start_stream(input int n);
        for (int i = 0; i < NDUT; i++) begin
            rp[i] = 0;
            fe[i] = (n == 0);
            fd[i] = bytes_a[0];
        end
    endtask

    task automatic run(input int n);
        start_stream(n);
        for (int j = 0; j <= n * 12 * C + 3; j++) cycle(j, n);
    endtask

    task automatic idle_cycles(input int ncyc);
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            check_all(j, 4'b1000);
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) fd[i] = 8'($urandom);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        fe    = '1;
        for (int i = 0; i < NDUT; i++) fd[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all(-1, 4'b1000);
        rst_n = 1'b1;

        idle_cycles(200);

        bytes_a[0] = 8'h55;
        run(1);
        bytes_a[0] = 8'hA5;
        bytes_a[1] = 8'h3C;
        run(2);
        bytes_a[0] = 8'h07;
        run(1);
        bytes_a[0] = 8'hFF;
        run(1);

        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < 8; k++) bytes_a[k] = 8'($urandom);
            run(n);
        end

        // Reset during the third data bit of 0x0F, with the FIFO offering data.
        bytes_a[0] = 8'h0F;
        start_stream(1);
        for (int j = 0; j <= 14; j++) cycle(j, 1);
        #2;
        fe    = '0;
        rst_n = 1'b0;
        #1;
        check_all(100, 4'b1000);
        @(posedge clk);
        #1;
        check_all(101, 4'b1000);
        fe    = '1;
        rst_n = 1'b1;
        idle_cycles(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
